seg7_scan_ctrl: RTL and testbench

Time-multiplexed 8-digit seven-segment display controller sitting downstream of the pipeline CPU top level. It consumes the 32-bit value the CPU exposes for display (selected register or memory word) and drives the board's segment and anode pins (`disp_seg_o`, `disp_an_o`). New data is double-buffered and committed only at frame boundaries, so a digit never tears mid-scan. Per-digit blanking, decimal points and leading-zero suppression are supported.

---
 rtl/seg7_scan_ctrl.sv | 108 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned double buffering,
// per-digit blanking, decimal points and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  blank_i,
    input  logic [7:0]  dp_i,
    input  logic        lz_en_i,
    output logic [7:0]  disp_seg_o,
    output logic [7:0]  disp_an_o,
    output logic [2:0]  digit_idx_o,
    output logic        frame_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      active;
    logic [31:0]      pending;
    logic             pend_v;

    logic             tick;
    logic             boundary;
    logic             blank_cur;
    logic [3:0]       nib_cur;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] k);
        logic [31:0] upper;
        upper = val >> {k, 2'b00};
        return (k != 3'd0) && (upper == 32'd0);
    endfunction

    always_comb begin
        tick      = (cnt == CNT_LAST);
        boundary  = tick && (idx == 3'd7);
        nib_cur   = active[{idx, 2'b00} +: 4];
        blank_cur = blank_i[idx] || (lz_en_i && lz_blank(active, idx));
    end

    assign digit_idx_o = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            active     <= 32'd0;
            pending    <= 32'd0;
            pend_v     <= 1'b0;
            frame_o    <= 1'b0;
            disp_an_o  <= 8'hFF;
            disp_seg_o <= 8'hFF;
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            if (tick)
                idx <= idx + 3'd1;
            frame_o <= boundary;

            // The boundary commits the value pending before this edge; a coincident load stays pending.
            if (boundary && pend_v)
                active <= pending;
            if (load_i) begin
                pending <= data_i;
                pend_v  <= 1'b1;
            end else if (boundary) begin
                pend_v  <= 1'b0;
            end

            if (blank_cur) begin
                disp_an_o  <= 8'hFF;
                disp_seg_o <= 8'hFF;
            end else begin
                disp_an_o  <= ~(8'd1 << idx);
                disp_seg_o <= {~dp_i[idx], hex_seg(nib_cur)};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: edge-counting reference model of the scan, frame commits and blanking.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;
    localparam int FR = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = 32'd0;
    logic        load_i = 1'b0;
    logic [7:0]  blank_i = 8'd0;
    logic [7:0]  dp_i = 8'd0;
    logic        lz_en_i = 1'b0;
    logic [7:0]  disp_seg_o;
    logic [7:0]  disp_an_o;
    logic [2:0]  digit_idx_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;

    // Model: n = rising edges since reset release; scan position follows from n alone.
    int          n;
    logic [31:0] m_active, m_pend;
    bit          m_pv;
    logic [7:0]  e_an, e_seg;
    logic [2:0]  e_idx;
    logic        e_frame;
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .load_i(load_i), .blank_i(blank_i),
        .dp_i(dp_i), .lz_en_i(lz_en_i), .disp_seg_o(disp_seg_o), .disp_an_o(disp_an_o),
        .digit_idx_o(digit_idx_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        n = 0; m_active = 32'd0; m_pend = 32'd0; m_pv = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [31:0] d);
        logic [2:0] k;
        logic [3:0] nib;
        bit         dark;
        k    = 3'((n / SD) % 8);
        nib  = m_active[4*k +: 4];
        dark = blank_i[k];
        if (lz_en_i && k != 3'd0) begin
            bit allz = 1'b1;
            for (int j = 0; j < 8; j++)
                if (j >= int'(k) && m_active[4*j +: 4] != 4'd0) allz = 1'b0;
            if (allz) dark = 1'b1;
        end
        if (dark) begin
            e_an = 8'hFF; e_seg = 8'hFF;
        end else begin
            e_an = 8'hFF; e_an[k] = 1'b0;
            e_seg = {~dp_i[k], hex_tab[nib]};
        end
        e_frame = ((n + 1) % FR == 0);
        if (e_frame && m_pv) begin m_active = m_pend; m_pv = 1'b0; end
        if (ld) begin m_pend = d; m_pv = 1'b1; end
        n++;
        e_idx = 3'((n / SD) % 8);
        load_i = ld; data_i = d;
        @(posedge clk); #1;
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state an/seg/idx/frame got %h/%h/%0d/%b exp FF/FF/0/0",
                     disp_an_o, disp_seg_o, digit_idx_o, frame_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 32'd0);
        checks++;
        if ({disp_an_o, disp_seg_o} !== {8'hFE, 8'hC0}) begin
            errors++;
            $display("FAIL first_edge an/seg got %h/%h exp FE/C0", disp_an_o, disp_seg_o);
        end
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL idle_scan n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
    endtask

    task automatic test_load_midframe();
        int target;
        target = 10 + $urandom_range(0, 10);
        while (n % FR != target) step(1'b0, 32'd0);
        step(1'b1, 32'h89ABCDEF);
        for (int i = 0; i < 2 * FR + 3; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL load_midframe n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
    endtask

    task automatic test_load_on_boundary();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        while (n % FR != 5) step(1'b0, 32'd0);
        step(1'b1, a);
        while (n % FR != FR - 1) step(1'b0, 32'd0);
        step(1'b1, b);
        for (int i = 0; i < 2 * FR + 3; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL load_boundary n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
    endtask

    task automatic test_lz();
        logic [31:0] vals [3] = '{32'h0000_0100, 32'h0000_0000, 32'h00A0_0000};
        lz_en_i = 1'b1;
        for (int v = 0; v < 3; v++) begin
            step(1'b1, vals[v]);
            for (int i = 0; i < 2 * FR; i++) begin
                step(1'b0, 32'd0);
                checks++;
                if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                    errors++;
                    $display("FAIL lz_suppress v=%h n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", vals[v], n,
                             disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
                end
            end
        end
        lz_en_i = 1'b0;
    endtask

    task automatic test_blank_dp();
        blank_i = 8'h01; dp_i = 8'h02;
        step(1'b1, $urandom);
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL blank_dp n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
        blank_i = 8'h00; dp_i = 8'h00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FR; i++) begin
            if (i % 8 == 0) begin
                blank_i = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                dp_i    = 8'($urandom);
                lz_en_i = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0)
                step(1'b1, $urandom >> (4 * $urandom_range(0, 7)));
            else
                step(1'b0, $urandom);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL random n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
        blank_i = 8'h00; dp_i = 8'h00; lz_en_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        while ((n / SD) % 8 != 5) step(1'b0, 32'd0);
        step(1'b1, 32'h1234_5678);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %h/%h/%0d/%b exp FF/FF/0/0",
                     disp_an_o, disp_seg_o, digit_idx_o, frame_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FR + 2; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if ({disp_an_o, disp_seg_o, digit_idx_o, frame_o} !== {e_an, e_seg, e_idx, e_frame}) begin
                errors++;
                $display("FAIL after_reset n=%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                         disp_an_o, disp_seg_o, digit_idx_o, frame_o, e_an, e_seg, e_idx, e_frame);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_midframe();
        test_load_on_boundary();
        test_lz();
        test_blank_dp();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
